irs_block_lock_requester: RTL and testbench
===========================================

IRS_BLOCK_LOCK_REQUESTER -- requirements
Module: irs_block_lock_requester

Interface
REQ-001 SHALL have parameter DEPTH, default 16, address ring entries (power of 2, 4..64).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, cycles allowed from strobe to ack.
REQ-003 SHALL have port clk_i  in  1  sole clock.
REQ-004 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trig_i  in  1  request lock of trig_addr_i; one-cycle pulse.
REQ-006 SHALL have port trig_addr_i  in  9  IRS block address to lock.
REQ-007 SHALL have port trig_ready_o  out  1  ring not full.
REQ-008 SHALL have port done_i  in  1  readout of oldest locked block finished; one-cycle pulse.
REQ-009 SHALL have port lock_address_o  out  9  block address for lock strobe.
REQ-010 SHALL have port lock_o  out  1  lock/unlock qualifier; always 1.
REQ-011 SHALL have port lock_strobe_o  out  1  lock request, one cycle.
REQ-012 SHALL have port lock_ack_i  in  1  lock acknowledge from buffer manager.
REQ-013 SHALL have port free_address_o  out  9  block address for free strobe.
REQ-014 SHALL have port free_strobe_o  out  1  free request, one cycle.
REQ-015 SHALL have port free_ack_i  in  1  free acknowledge from buffer manager.
REQ-016 SHALL have port oldest_valid_o / oldest_addr_o  out  1/9  oldest locked block present, and its address.
REQ-017 SHALL have port locked_count_o  out  7  blocks locked and not yet freed.
REQ-018 SHALL have port err_o  out  3  sticky: [0] overflow, [1] spurious done, [2] ack timeout.

Function
REQ-019 SHALL hold addresses in one ring with pointers wr, lk, fr: entries fr..lk-1 locked, lk..wr-1 pending lock.
REQ-020 SHALL accept trig_i when trig_ready_o=1, storing at wr, advancing wr next cycle; trig_ready_o = (wr-fr) != DEPTH.
REQ-021 SHALL drop trig_i while full and set err_o[0].
REQ-022 SHALL count done_i into pend_free when pend_free < locked_count; otherwise ignore it and set err_o[1].
REQ-023 SHALL run FSM IDLE, LOCK, LOCK_WAIT, FREE, FREE_WAIT.
REQ-024 IDLE SHALL go to LOCK if lk!=wr, else to FREE if pend_free!=0; lock has priority.
REQ-025 LOCK SHALL assert lock_strobe_o for exactly one cycle with lock_address_o=ring[lk], then go to LOCK_WAIT.
REQ-026 LOCK_WAIT SHALL, on lock_ack_i, advance lk and return to IDLE.
REQ-027 FREE SHALL assert free_strobe_o for one cycle with free_address_o=ring[fr], then go to FREE_WAIT.
REQ-028 FREE_WAIT SHALL, on free_ack_i, advance fr, decrement pend_free and return to IDLE.
REQ-029 Consecutive strobes of either kind SHALL be at least 2 cycles apart; with a 1-cycle ack they SHALL occur every 3 cycles.
REQ-030 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; locked_count_o = lk-fr.
REQ-031 oldest_valid_o SHALL equal (lk!=fr), and oldest_addr_o SHALL equal ring[fr].
REQ-032 Simultaneous trig_i, done_i and ack SHALL all be honoured in the same cycle.
REQ-033 Acks arriving outside the matching WAIT state SHALL be ignored.

Reset
REQ-034 rst_n_i low SHALL asynchronously clear pointers, pend_free and err_o, and set FSM to IDLE.
REQ-035 During reset, strobes and address outputs SHALL be 0, trig_ready_o 0 and oldest_valid_o 0; lock_o SHALL stay 1.
REQ-036 Reset deassertion SHALL be synchronised internally; trig_ready_o SHALL rise on the second clock after release.
REQ-037 Reset mid-handshake SHALL abandon the transaction with no further strobe.

Configuration
REQ-038 With IRS_LOCK_REQ_TIMEOUT_EN defined, a WAIT state exceeding ACK_TIMEOUT cycles SHALL set err_o[2] and advance as if acked.
REQ-039 Without IRS_LOCK_REQ_TIMEOUT_EN, WAIT states SHALL wait indefinitely, and err_o[2] SHALL read 0.

Structure
REQ-040 Package irs_lock_req_pkg SHALL hold the FSM state enum, ADDR_W=9 and the default DEPTH and ACK_TIMEOUT.
REQ-041 The ring storage and pointers SHALL be sub-module irs_addr_ring; the FSM, counters and errors SHALL be in the top.

Verification
REQ-042 Trig 0x005 with a 1-cycle ack responder -> lock_strobe_o with address 0x005 two cycles later; locked_count_o=1; oldest_addr_o=0x005.
REQ-043 17 trigs back-to-back with no acks, DEPTH=16 -> trig_ready_o low after the 16th; err_o[0]=1; 17th address never strobed.
REQ-044 Lock 0x010 and 0x011, then done_i twice -> free strobes 0x010 then 0x011 in order; locked_count_o=0.
REQ-045 done_i with nothing locked -> no free strobe; err_o[1]=1.
REQ-046 With IRS_LOCK_REQ_TIMEOUT_EN, lock_ack_i withheld -> err_o[2]=1 after 15 cycles; next strobe follows.
REQ-047 rst_n_i pulsed low during LOCK_WAIT -> outputs 0 immediately; after release no strobe until a new trig.

Source files
------------

// File: rtl/irs_lock_req_pkg.sv
// Shared types and defaults for the IRS block lock requester.
package irs_lock_req_pkg;

    localparam int unsigned ADDR_W          = 9;
    localparam int unsigned CNT_W           = 7;
    localparam int unsigned DEPTH_DEF       = 16;
    localparam int unsigned ACK_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_LOCK_WAIT,
        ST_FREE,
        ST_FREE_WAIT
    } lock_state_e;

endpackage

// File: rtl/irs_addr_ring.sv
// Address ring with three pointers: fr..lk-1 locked, lk..wr-1 waiting for a lock.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module irs_addr_ring
    import irs_lock_req_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              lk_adv_i,
    input  logic              fr_adv_i,
    output logic              full_o,
    output logic              lock_pend_o,
    output logic [CNT_W-1:0]  locked_count_o,
    output logic [ADDR_W-1:0] lk_addr_o,
    output logic [ADDR_W-1:0] fr_addr_o
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_q, lk_q, fr_q;
    logic [PW-1:0]     occ, lkd;

    // Storage is cleared too so address outputs read 0 while in reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            lk_q <= '0;
            fr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_i) begin
                mem[wr_q[PW-2:0]] <= push_addr_i;
                wr_q              <= wr_q + PW'(1);
            end
            if (lk_adv_i) lk_q <= lk_q + PW'(1);
            if (fr_adv_i) fr_q <= fr_q + PW'(1);
        end
    end

    assign occ            = wr_q - fr_q;
    assign lkd            = lk_q - fr_q;
    assign full_o         = (occ == PW'(DEPTH));
    assign lock_pend_o    = (lk_q != wr_q);
    assign locked_count_o = CNT_W'(lkd);
    assign lk_addr_o      = mem[lk_q[PW-2:0]];
    assign fr_addr_o      = mem[fr_q[PW-2:0]];

endmodule

// File: rtl/irs_block_lock_requester.sv
// Locks triggered IRS blocks and frees them in order as readouts complete.
// Define IRS_LOCK_REQ_TIMEOUT_EN to bound ack waits by ACK_TIMEOUT cycles.
module irs_block_lock_requester
    import irs_lock_req_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              trig_i,
    input  logic [ADDR_W-1:0] trig_addr_i,
    output logic              trig_ready_o,
    input  logic              done_i,
    output logic [ADDR_W-1:0] lock_address_o,
    output logic              lock_o,
    output logic              lock_strobe_o,
    input  logic              lock_ack_i,
    output logic [ADDR_W-1:0] free_address_o,
    output logic              free_strobe_o,
    input  logic              free_ack_i,
    output logic              oldest_valid_o,
    output logic [ADDR_W-1:0] oldest_addr_o,
    output logic [CNT_W-1:0]  locked_count_o,
    output logic [2:0]        err_o
);

    logic              rst_meta_n, rst_sync_n;
    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  pend_free_q;
    logic [2:0]        err_q;
    logic              full, lock_pend, push, lk_adv, fr_adv, done_acc;
    logic              ack_to, to_err;
    logic [ADDR_W-1:0] lk_addr, fr_addr;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) {rst_sync_n, rst_meta_n} <= 2'b00;
        else          {rst_sync_n, rst_meta_n} <= {rst_meta_n, 1'b1};
    end

    irs_addr_ring #(.DEPTH(DEPTH)) u_ring (
        .clk_i          (clk_i),
        .rst_n_i        (rst_sync_n),
        .push_i         (push),
        .push_addr_i    (trig_addr_i),
        .lk_adv_i       (lk_adv),
        .fr_adv_i       (fr_adv),
        .full_o         (full),
        .lock_pend_o    (lock_pend),
        .locked_count_o (locked_count_o),
        .lk_addr_o      (lk_addr),
        .fr_addr_o      (fr_addr)
    );

    assign trig_ready_o = rst_sync_n & ~full;
    assign push         = trig_i & trig_ready_o;
    assign done_acc     = done_i && (pend_free_q < locked_count_o);

`ifdef IRS_LOCK_REQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] tmr_q;
    logic            in_wait, wait_ack;

    assign in_wait  = (state_q == ST_LOCK_WAIT) || (state_q == ST_FREE_WAIT);
    assign wait_ack = ((state_q == ST_LOCK_WAIT) && lock_ack_i) ||
                      ((state_q == ST_FREE_WAIT) && free_ack_i);
    assign ack_to   = in_wait && (tmr_q == TO_W'(ACK_TIMEOUT - 1));
    assign to_err   = ack_to && !wait_ack;

    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) tmr_q <= '0;
        else             tmr_q <= in_wait ? tmr_q + TO_W'(1) : '0;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (ACK_TIMEOUT != 0);
    assign ack_to         = 1'b0;
    assign to_err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lk_adv  = 1'b0;
        fr_adv  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lock_pend)                state_d = ST_LOCK;
                else if (pend_free_q != '0)   state_d = ST_FREE;
            end
            ST_LOCK: state_d = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                if (lock_ack_i || ack_to) begin
                    lk_adv  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FREE: state_d = ST_FREE_WAIT;
            ST_FREE_WAIT: begin
                if (free_ack_i || ack_to) begin
                    fr_adv  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= ST_IDLE;
            pend_free_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_free_q <= pend_free_q + CNT_W'(done_acc) - CNT_W'(fr_adv);
            err_q       <= err_q | {to_err, done_i & ~done_acc, trig_i & ~trig_ready_o};
        end
    end

    assign lock_o         = 1'b1;
    assign lock_strobe_o  = (state_q == ST_LOCK);
    assign free_strobe_o  = (state_q == ST_FREE);
    assign lock_address_o = lk_addr;
    assign free_address_o = fr_addr;
    assign oldest_addr_o  = fr_addr;
    assign oldest_valid_o = (locked_count_o != '0);
    assign err_o          = err_q;

endmodule

// File: tb/tb_irs_block_lock_requester.sv
// Directed bench for irs_block_lock_requester with an auto-ack responder.
module tb_irs_block_lock_requester;

    logic       clk = 1'b0, rst_n = 1'b1, trig = 1'b0, done = 1'b0;
    logic       lock_ack = 1'b0, free_ack = 1'b0;
    logic [8:0] trig_addr = '0;
    logic       trig_ready, lock_o, lock_strobe, free_strobe, oldest_valid;
    logic [8:0] lock_addr, free_addr, oldest_addr;
    logic [6:0] locked_count;
    logic [2:0] err;

    int   compared = 0, mismatched = 0, cyc = 0;
    logic lack_en = 1'b0, fack_en = 1'b0, man_lack = 1'b0, lk_seen = 1'b0, fr_seen = 1'b0;
    logic [8:0] lk_aq[$], fr_aq[$];
    int         lk_cq[$], fr_cq[$];

    irs_block_lock_requester dut (
        .clk_i(clk), .rst_n_i(rst_n), .trig_i(trig), .trig_addr_i(trig_addr),
        .trig_ready_o(trig_ready), .done_i(done), .lock_address_o(lock_addr),
        .lock_o(lock_o), .lock_strobe_o(lock_strobe), .lock_ack_i(lock_ack),
        .free_address_o(free_addr), .free_strobe_o(free_strobe), .free_ack_i(free_ack),
        .oldest_valid_o(oldest_valid), .oldest_addr_o(oldest_addr),
        .locked_count_o(locked_count), .err_o(err)
    );

    always #5 clk = ~clk;

    // Strobe log, sampled mid-cycle.
    always @(negedge clk) begin
        lk_seen = lock_strobe;
        fr_seen = free_strobe;
        if (lock_strobe) begin lk_aq.push_back(lock_addr); lk_cq.push_back(cyc); end
        if (free_strobe) begin fr_aq.push_back(free_addr); fr_cq.push_back(cyc); end
    end

    // Responder: ack is high for the cycle right after a strobe.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        lock_ack = (lack_en & lk_seen) | man_lack;
        free_ack = fack_en & fr_seen;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; trig = 1'b0; done = 1'b0;
        lack_en = 1'b0; fack_en = 1'b0; man_lack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if ({lock_strobe, free_strobe, oldest_valid, trig_ready} !== 4'b0) begin mismatched++; $display("FAIL rst_flags: got %b exp 0000", {lock_strobe, free_strobe, oldest_valid, trig_ready}); end
        compared++; if ({lock_addr, free_addr, oldest_addr} !== 27'h0) begin mismatched++; $display("FAIL rst_addrs: got %h/%h/%h exp 0", lock_addr, free_addr, oldest_addr); end
        compared++; if (lock_o !== 1'b1) begin mismatched++; $display("FAIL rst_lock_o: got %b exp 1", lock_o); end
        compared++; if ({err, locked_count} !== 10'h0) begin mismatched++; $display("FAIL rst_err_cnt: got %h/%h exp 0", err, locked_count); end
        @(negedge clk) rst_n = 1'b1;
        step(1);
        compared++; if (trig_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready_clk1: got %b exp 0", trig_ready); end
        step(1);
        compared++; if (trig_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready_clk2: got %b exp 1", trig_ready); end
    endtask

    task automatic test_single_lock();
        int lb, c;
        do_reset();
        lack_en = 1'b1;
        lb = lk_aq.size(); c = cyc;
        trig = 1'b1; trig_addr = 9'h005;
        step(); trig = 1'b0;
        step(6);
        compared++; if (lk_aq.size() - lb !== 1) begin mismatched++; $display("FAIL single_nstrobe: got %0d exp 1", lk_aq.size() - lb); end
        if (lk_aq.size() > lb) begin
            compared++; if (lk_aq[lb] !== 9'h005) begin mismatched++; $display("FAIL single_addr: got %h exp 005", lk_aq[lb]); end
            compared++; if (lk_cq[lb] !== c + 2) begin mismatched++; $display("FAIL single_latency: got %0d exp %0d", lk_cq[lb], c + 2); end
        end
        compared++; if (locked_count !== 7'd1) begin mismatched++; $display("FAIL single_count: got %0d exp 1", locked_count); end
        compared++; if ({oldest_valid, oldest_addr} !== {1'b1, 9'h005}) begin mismatched++; $display("FAIL single_oldest: got %b/%h exp 1/005", oldest_valid, oldest_addr); end
    endtask

    task automatic test_back_to_back();
        int lb;
        do_reset();
        lack_en = 1'b1;
        lb = lk_aq.size();
        for (int i = 0; i < 3; i++) begin
            trig = 1'b1; trig_addr = 9'h020 + 9'(i);
            step();
        end
        trig = 1'b0;
        step(12);
        compared++; if (lk_aq.size() - lb !== 3) begin mismatched++; $display("FAIL b2b_nstrobe: got %0d exp 3", lk_aq.size() - lb); end
        if (lk_aq.size() - lb == 3) begin
            compared++; if ({lk_aq[lb], lk_aq[lb+1], lk_aq[lb+2]} !== {9'h020, 9'h021, 9'h022}) begin mismatched++; $display("FAIL b2b_order: got %h %h %h exp 020 021 022", lk_aq[lb], lk_aq[lb+1], lk_aq[lb+2]); end
            compared++; if ((lk_cq[lb+1] - lk_cq[lb] !== 3) || (lk_cq[lb+2] - lk_cq[lb+1] !== 3)) begin mismatched++; $display("FAIL b2b_spacing: got %0d,%0d exp 3,3", lk_cq[lb+1] - lk_cq[lb], lk_cq[lb+2] - lk_cq[lb+1]); end
        end
        compared++; if (locked_count !== 7'd3) begin mismatched++; $display("FAIL b2b_count: got %0d exp 3", locked_count); end
    endtask

    task automatic test_overflow();
        int lb;
        do_reset();
        lb = lk_aq.size();
        for (int i = 0; i < 17; i++) begin
            trig = 1'b1; trig_addr = 9'h100 + 9'(i);
            step();
            if (i == 15) begin
                compared++; if (trig_ready !== 1'b0) begin mismatched++; $display("FAIL ovf_ready: got %b exp 0", trig_ready); end
            end
        end
        trig = 1'b0;
        compared++; if (err[0] !== 1'b1) begin mismatched++; $display("FAIL ovf_err0: got %b exp 1", err[0]); end
        lack_en = 1'b1;
        @(negedge clk) man_lack = 1'b1;
        @(negedge clk) man_lack = 1'b0;
        step(60);
        compared++; if (lk_aq.size() - lb !== 16) begin mismatched++; $display("FAIL ovf_nstrobe: got %0d exp 16", lk_aq.size() - lb); end
        if (lk_aq.size() > lb) begin
            compared++; if (lk_aq[lk_aq.size()-1] !== 9'h10F) begin mismatched++; $display("FAIL ovf_last: got %h exp 10f", lk_aq[lk_aq.size()-1]); end
        end
        compared++; if ({trig_ready, locked_count} !== {1'b0, 7'd16}) begin mismatched++; $display("FAIL ovf_full: got %b/%0d exp 0/16", trig_ready, locked_count); end
    endtask

    task automatic test_lock_free();
        int fb;
        do_reset();
        lack_en = 1'b1; fack_en = 1'b1;
        fb = fr_aq.size();
        trig = 1'b1; trig_addr = 9'h010; step();
        trig_addr = 9'h011; step();
        trig = 1'b0;
        step(10);
        compared++; if (locked_count !== 7'd2) begin mismatched++; $display("FAIL lf_locked: got %0d exp 2", locked_count); end
        done = 1'b1; step(2); done = 1'b0;
        step(15);
        compared++; if (fr_aq.size() - fb !== 2) begin mismatched++; $display("FAIL lf_nfree: got %0d exp 2", fr_aq.size() - fb); end
        if (fr_aq.size() - fb == 2) begin
            compared++; if ({fr_aq[fb], fr_aq[fb+1]} !== {9'h010, 9'h011}) begin mismatched++; $display("FAIL lf_order: got %h %h exp 010 011", fr_aq[fb], fr_aq[fb+1]); end
        end
        compared++; if ({locked_count, oldest_valid, err} !== 11'h0) begin mismatched++; $display("FAIL lf_final: got %0d/%b/%b exp 0/0/000", locked_count, oldest_valid, err); end
    endtask

    task automatic test_spurious_done();
        int fb;
        do_reset();
        fack_en = 1'b1;
        fb = fr_aq.size();
        done = 1'b1; step(); done = 1'b0;
        step(6);
        compared++; if (fr_aq.size() !== fb) begin mismatched++; $display("FAIL spur_nfree: got %0d exp 0", fr_aq.size() - fb); end
        compared++; if (err !== 3'b010) begin mismatched++; $display("FAIL spur_err: got %b exp 010", err); end
    endtask

    task automatic test_simultaneous();
        int lb, fb;
        do_reset();
        lack_en = 1'b1; fack_en = 1'b1;
        lb = lk_aq.size(); fb = fr_aq.size();
        trig = 1'b1; trig_addr = 9'h030; step(); trig = 1'b0;
        step(8);
        trig = 1'b1; trig_addr = 9'h031; step(); trig = 1'b0;
        step(2);
        // This edge also samples the ack for 0x031.
        trig = 1'b1; trig_addr = 9'h032; done = 1'b1;
        step(); trig = 1'b0; done = 1'b0;
        step(15);
        compared++; if (lk_aq.size() - lb !== 3 || fr_aq.size() - fb !== 1) begin mismatched++; $display("FAIL sim_counts: got lock %0d free %0d exp 3 1", lk_aq.size() - lb, fr_aq.size() - fb); end
        if (lk_aq.size() - lb == 3 && fr_aq.size() - fb == 1) begin
            compared++; if ({lk_aq[lb+1], lk_aq[lb+2], fr_aq[fb]} !== {9'h031, 9'h032, 9'h030}) begin mismatched++; $display("FAIL sim_addrs: got %h %h %h exp 031 032 030", lk_aq[lb+1], lk_aq[lb+2], fr_aq[fb]); end
            compared++; if (!(fr_cq[fb] > lk_cq[lb+2])) begin mismatched++; $display("FAIL sim_priority: got free@%0d lock@%0d exp lock first", fr_cq[fb], lk_cq[lb+2]); end
        end
        compared++; if ({locked_count, oldest_addr, err} !== {7'd2, 9'h031, 3'b000}) begin mismatched++; $display("FAIL sim_final: got %0d/%h/%b exp 2/031/000", locked_count, oldest_addr, err); end
    endtask

    task automatic test_timeout();
        int lb, c;
        do_reset();
        lb = lk_aq.size(); c = cyc;
        trig = 1'b1; trig_addr = 9'h0AA; step();
        trig_addr = 9'h0AB; step();
        trig = 1'b0;
`ifdef IRS_LOCK_REQ_TIMEOUT_EN
        step(15);
        compared++; if (err[2] !== 1'b0) begin mismatched++; $display("FAIL to_early: got %b exp 0", err[2]); end
        step();
        compared++; if (err[2] !== 1'b1) begin mismatched++; $display("FAIL to_err2: got %b exp 1", err[2]); end
        step(2);
        compared++; if (lk_aq.size() - lb !== 2) begin mismatched++; $display("FAIL to_nstrobe: got %0d exp 2", lk_aq.size() - lb); end
        if (lk_aq.size() - lb == 2) begin
            compared++; if ({lk_aq[lb+1], lk_cq[lb+1]} !== {9'h0AB, c + 19}) begin mismatched++; $display("FAIL to_next: got %h@%0d exp 0ab@%0d", lk_aq[lb+1], lk_cq[lb+1], c + 19); end
        end
`else
        step(30);
        compared++; if ({err[2], locked_count} !== 8'h0) begin mismatched++; $display("FAIL wait_hold: got %b/%0d exp 0/0", err[2], locked_count); end
        compared++; if (lk_aq.size() - lb !== 1) begin mismatched++; $display("FAIL wait_nstrobe: got %0d exp 1", lk_aq.size() - lb); end
        @(negedge clk) man_lack = 1'b1;
        @(negedge clk) man_lack = 1'b0;
        step(4);
        compared++; if (lk_aq.size() - lb !== 2) begin mismatched++; $display("FAIL wait_next: got %0d exp 2", lk_aq.size() - lb); end
        if (lk_aq.size() - lb == 2) begin
            compared++; if (lk_aq[lb+1] !== 9'h0AB) begin mismatched++; $display("FAIL wait_addr: got %h exp 0ab", lk_aq[lb+1]); end
        end
        compared++; if ({err[2], locked_count} !== {1'b0, 7'd1}) begin mismatched++; $display("FAIL wait_final: got %b/%0d exp 0/1", err[2], locked_count); end
`endif
    endtask

    task automatic test_reset_mid();
        int lb;
        do_reset();
        trig = 1'b1; trig_addr = 9'h0C0; step(); trig = 1'b0;
        step(3);
        compared++; if ({locked_count, lock_addr} !== {7'd0, 9'h0C0}) begin mismatched++; $display("FAIL mid_pre: got %0d/%h exp 0/0c0", locked_count, lock_addr); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if ({lock_strobe, trig_ready, oldest_valid} !== 3'b000) begin mismatched++; $display("FAIL mid_flags: got %b exp 000", {lock_strobe, trig_ready, oldest_valid}); end
        compared++; if ({lock_addr, free_addr, locked_count} !== 25'h0) begin mismatched++; $display("FAIL mid_addrs: got %h/%h/%0d exp 0", lock_addr, free_addr, locked_count); end
        @(negedge clk) rst_n = 1'b1; lack_en = 1'b1;
        lb = lk_aq.size();
        step(12);
        compared++; if (lk_aq.size() !== lb) begin mismatched++; $display("FAIL mid_quiet: got %0d strobes exp 0", lk_aq.size() - lb); end
        trig = 1'b1; trig_addr = 9'h0C1; step(); trig = 1'b0;
        step(5);
        compared++; if (lk_aq.size() - lb !== 1) begin mismatched++; $display("FAIL mid_new: got %0d strobes exp 1", lk_aq.size() - lb); end
        if (lk_aq.size() > lb) begin
            compared++; if (lk_aq[lb] !== 9'h0C1) begin mismatched++; $display("FAIL mid_addr: got %h exp 0c1", lk_aq[lb]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_lock();
        test_back_to_back();
        test_overflow();
        test_lock_free();
        test_spurious_done();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
